// File: rtl/multi_button_debouncer.sv
// Multi-channel push-button conditioner: 2-flop sync, stable-sample debounce,
// and registered press/release/long-press/auto-repeat strobes per channel.
// `release` and `repeat` are reserved words, so those ports carry a _stb suffix.
module multi_button_debouncer #(
    parameter int unsigned CHANNELS           = 4,
    parameter int unsigned STABLE_SAMPLES     = 20,
    parameter int unsigned SAMPLE_DIV         = 1,
    parameter int unsigned LONG_PRESS_SAMPLES = 10000,
    parameter int unsigned REPEAT_SAMPLES     = 1000,
    parameter int unsigned RELEASE_FAST       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_stb,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] repeat_stb
);

    localparam int unsigned SCW    = $clog2(STABLE_SAMPLES + 1);
    localparam int unsigned HC_MAX = (LONG_PRESS_SAMPLES > REPEAT_SAMPLES) ?
                                     LONG_PRESS_SAMPLES : REPEAT_SAMPLES;
    localparam int unsigned HCW    = $clog2(HC_MAX + 1);
    localparam int unsigned DIVW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [SCW-1:0]  SC_LAST  = SCW'(STABLE_SAMPLES - 1);
    localparam logic [HCW-1:0]  HC_LONG  = HCW'(LONG_PRESS_SAMPLES);
    localparam logic [HCW-1:0]  HC_RPT   = HCW'(REPEAT_SAMPLES);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SAMPLE_DIV - 1);

    typedef enum logic {
        PH_HOLD   = 1'b0,
        PH_REPEAT = 1'b1
    } phase_e;

    logic [DIVW-1:0]     div_q, div_d;
    logic                tick;
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] s_q, s_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CHANNELS-1:0] long_q, long_d;
    logic [CHANNELS-1:0] repeat_q, repeat_d;
    logic [SCW-1:0]      sc_q [CHANNELS];
    logic [SCW-1:0]      sc_d [CHANNELS];
    logic [HCW-1:0]      hc_q [CHANNELS];
    logic [HCW-1:0]      hc_d [CHANNELS];
    phase_e              phase_q [CHANNELS];
    phase_e              phase_d [CHANNELS];
    logic [HCW-1:0]      hc_inc;

    always_comb begin
        tick    = (div_q == DIV_LAST);
        div_d   = tick ? '0 : div_q + DIVW'(1);
        sync1_d = button;
        s_d     = sync1_q;
        level_d = level_q;
        sc_d    = sc_q;
        hc_d    = hc_q;
        phase_d = phase_q;
        long_d  = '0;
        repeat_d = '0;
        hc_inc  = '0;

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (tick) begin
                if (s_q[i] == level_q[i]) begin
                    sc_d[i] = '0;
                end else if (RELEASE_FAST != 0 && level_q[i]) begin
                    level_d[i] = 1'b0;
                    sc_d[i]    = '0;
                end else if (sc_q[i] == SC_LAST) begin
                    level_d[i] = ~level_q[i];
                    sc_d[i]    = '0;
                end else begin
                    sc_d[i] = sc_q[i] + SCW'(1);
                end
            end

            // Hold timing only runs while the level stays high across the edge,
            // so the press edge itself is hold tick zero.
            hc_inc = hc_q[i] + HCW'(1);
            if (!(level_q[i] && level_d[i])) begin
                hc_d[i]    = '0;
                phase_d[i] = PH_HOLD;
            end else if (tick) begin
                case (phase_q[i])
                    PH_HOLD: begin
                        if (hc_inc == HC_LONG) begin
                            long_d[i]  = 1'b1;
                            hc_d[i]    = '0;
                            phase_d[i] = PH_REPEAT;
                        end else begin
                            hc_d[i] = hc_inc;
                        end
                    end
                    PH_REPEAT: begin
                        if (REPEAT_SAMPLES != 0) begin
                            if (hc_inc == HC_RPT) begin
                                repeat_d[i] = 1'b1;
                                hc_d[i]     = '0;
                            end else begin
                                hc_d[i] = hc_inc;
                            end
                        end
                    end
                    default: phase_d[i] = PH_HOLD;
                endcase
            end
        end

        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            sync1_q   <= '0;
            s_q       <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                sc_q[i]    <= '0;
                hc_q[i]    <= '0;
                phase_q[i] <= PH_HOLD;
            end
        end else begin
            div_q     <= div_d;
            sync1_q   <= sync1_d;
            s_q       <= s_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                sc_q[i]    <= sc_d[i];
                hc_q[i]    <= hc_d[i];
                phase_q[i] <= phase_d[i];
            end
        end
    end

    assign level       = level_q;
    assign press       = press_q;
    assign release_stb = release_q;
    assign long_press  = long_q;
    assign repeat_stb  = repeat_q;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: two configurations checked every cycle
// against a tick-counting reference model, plus directed latency checks.
module tb_multi_button_debouncer;

    localparam int A_CH = 2, A_ST = 4, A_DIV = 1, A_LP = 16, A_RP = 4, A_FAST = 0;
    localparam int B_CH = 3, B_ST = 4, B_DIV = 5, B_LP = 6,  B_RP = 0, B_FAST = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [A_CH-1:0]  btn_a, lvl_a, prs_a, rel_a, lng_a, rpt_a;
    logic [B_CH-1:0]  btn_b, lvl_b, prs_b, rel_b, lng_b, rpt_b;

    multi_button_debouncer #(
        .CHANNELS(A_CH), .STABLE_SAMPLES(A_ST), .SAMPLE_DIV(A_DIV),
        .LONG_PRESS_SAMPLES(A_LP), .REPEAT_SAMPLES(A_RP), .RELEASE_FAST(A_FAST)
    ) dut_a (
        .clk(clk), .rst(rst), .button(btn_a), .level(lvl_a), .press(prs_a),
        .release_stb(rel_a), .long_press(lng_a), .repeat_stb(rpt_a)
    );

    multi_button_debouncer #(
        .CHANNELS(B_CH), .STABLE_SAMPLES(B_ST), .SAMPLE_DIV(B_DIV),
        .LONG_PRESS_SAMPLES(B_LP), .REPEAT_SAMPLES(B_RP), .RELEASE_FAST(B_FAST)
    ) dut_b (
        .clk(clk), .rst(rst), .button(btn_b), .level(lvl_b), .press(prs_b),
        .release_stb(rel_b), .long_press(lng_b), .repeat_stb(rpt_b)
    );

    typedef struct {
        bit sync1;
        bit s;
        bit lvl;
        int run;
        int held;
        bit pr;
        bit rl;
        bit lp;
        bit rp;
    } ch_t;

    ch_t ma [A_CH];
    ch_t mb [B_CH];
    int  na, nb;
    int  total, bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // held counts ticks the level has stayed high since the press edge.
    function automatic ch_t ch_step(ch_t c, bit btn, bit r, bit tk,
                                    int stable, int lpn, int rpn, bit fast);
        ch_t n;
        n    = c;
        n.pr = 1'b0;
        n.rl = 1'b0;
        n.lp = 1'b0;
        n.rp = 1'b0;
        if (r) begin
            n.sync1 = 1'b0; n.s = 1'b0; n.lvl = 1'b0; n.run = 0; n.held = 0;
            return n;
        end
        n.sync1 = btn;
        n.s     = c.sync1;
        if (tk) begin
            if (c.s == c.lvl) n.run = 0;
            else if (fast && c.lvl) begin n.lvl = 1'b0; n.run = 0; end
            else if (c.run + 1 == stable) begin n.lvl = !c.lvl; n.run = 0; end
            else n.run = c.run + 1;
        end
        n.pr = n.lvl && !c.lvl;
        n.rl = !n.lvl && c.lvl;
        if (c.lvl && n.lvl) begin
            if (tk) begin
                n.held = c.held + 1;
                n.lp   = (n.held == lpn);
                if (rpn > 0 && n.held > lpn) n.rp = ((n.held - lpn) % rpn) == 0;
            end
        end else begin
            n.held = 0;
        end
        return n;
    endfunction

    task automatic compare_all();
        logic [A_CH-1:0] el, ep, er, elp, erp;
        logic [B_CH-1:0] fl, fp, fr, flp, frp;
        for (int i = 0; i < A_CH; i++) begin
            el[i] = ma[i].lvl; ep[i] = ma[i].pr; er[i] = ma[i].rl;
            elp[i] = ma[i].lp; erp[i] = ma[i].rp;
        end
        for (int i = 0; i < B_CH; i++) begin
            fl[i] = mb[i].lvl; fp[i] = mb[i].pr; fr[i] = mb[i].rl;
            flp[i] = mb[i].lp; frp[i] = mb[i].rp;
        end
        check_eq("a_level", 32'(lvl_a), 32'(el));
        check_eq("a_press", 32'(prs_a), 32'(ep));
        check_eq("a_release", 32'(rel_a), 32'(er));
        check_eq("a_long", 32'(lng_a), 32'(elp));
        check_eq("a_repeat", 32'(rpt_a), 32'(erp));
        check_eq("b_level", 32'(lvl_b), 32'(fl));
        check_eq("b_press", 32'(prs_b), 32'(fp));
        check_eq("b_release", 32'(rel_b), 32'(fr));
        check_eq("b_long", 32'(lng_b), 32'(flp));
        check_eq("b_repeat", 32'(rpt_b), 32'(frp));
    endtask

    task automatic step();
        bit tka, tkb;
        @(posedge clk);
        if (rst) begin
            na = 0; nb = 0; tka = 1'b0; tkb = 1'b0;
        end else begin
            tka = (na % A_DIV) == A_DIV - 1;
            tkb = (nb % B_DIV) == B_DIV - 1;
            na++;
            nb++;
        end
        for (int i = 0; i < A_CH; i++)
            ma[i] = ch_step(ma[i], btn_a[i], rst, tka, A_ST, A_LP, A_RP, A_FAST != 0);
        for (int i = 0; i < B_CH; i++)
            mb[i] = ch_step(mb[i], btn_b[i], rst, tkb, B_ST, B_LP, B_RP, B_FAST != 0);
        @(negedge clk);
        compare_all();
    endtask

    // kind: 0 level, 1 press, 2 release, 3 long, 4 repeat, 5 level low
    function automatic bit sig_of(int inst, int kind, int ch);
        logic [2:0] v;
        v = '0;
        case (kind)
            0, 5: v = (inst == 0) ? 3'(lvl_a) : lvl_b;
            1:    v = (inst == 0) ? 3'(prs_a) : prs_b;
            2:    v = (inst == 0) ? 3'(rel_a) : rel_b;
            3:    v = (inst == 0) ? 3'(lng_a) : lng_b;
            default: v = (inst == 0) ? 3'(rpt_a) : rpt_b;
        endcase
        return (kind == 5) ? !v[ch] : v[ch];
    endfunction

    task automatic wait_for(input int inst, input int kind, input int ch,
                            input int limit, output int edge_idx);
        edge_idx = -1;
        for (int k = 0; k < limit; k++) begin
            step();
            if (sig_of(inst, kind, ch)) begin
                edge_idx = k;
                break;
            end
        end
    endtask

    function automatic int tick_edge(int m, int nth);
        int cnt;
        cnt = 0;
        for (int k = 2; k < 200; k++) begin
            if ((m + k) % B_DIV == B_DIV - 1) begin
                cnt++;
                if (cnt == nth) return k;
            end
        end
        return -2;
    endfunction

    initial begin
        int e, pc, m, ha[A_CH], hb[B_CH];
        total = 0; bad = 0; na = 0; nb = 0;
        rst = 1'b1; btn_a = '0; btn_b = '0;
        step();
        step();
        check_eq("rst_level_a", 32'(lvl_a), 32'd0);
        check_eq("rst_level_b", 32'(lvl_b), 32'd0);
        rst = 1'b0;

        // press latency and single-cycle strobe
        btn_a[0] = 1'b1;
        wait_for(0, 1, 0, 20, e);
        check_eq("s1_press_edge", 32'(e), 32'd5);
        step();
        check_eq("s1_press_width", 32'(prs_a[0]), 32'd0);
        btn_a[0] = 1'b0;
        wait_for(0, 2, 0, 20, e);
        check_eq("s2_release_edge", 32'(e), 32'd5);

        // bounce shorter than the stable window
        pc = 0;
        for (int k = 0; k < 40; k++) begin
            btn_a[0] = ((k / 3) % 2) == 1;
            step();
            pc += int'(prs_a[0]) + int'(rel_a[0]) + int'(lvl_a[0]);
        end
        check_eq("s2_glitch_events", 32'(pc), 32'd0);
        btn_a[0] = 1'b0;
        repeat (10) step();

        // long press then periodic repeat, release, and re-arm
        btn_a[1] = 1'b1;
        wait_for(0, 1, 1, 20, e);
        check_eq("s3_press_edge", 32'(e), 32'd5);
        wait_for(0, 3, 1, 40, e);
        check_eq("s3_long_delay", 32'(e), 32'(A_LP - 1));
        for (int r = 0; r < 4; r++) begin
            wait_for(0, 4, 1, 20, e);
            check_eq("s3_repeat_delay", 32'(e), 32'(A_RP - 1));
        end
        btn_a[1] = 1'b0;
        wait_for(0, 2, 1, 20, e);
        check_eq("s3_release_edge", 32'(e), 32'd5);
        repeat (3) step();
        btn_a[1] = 1'b1;
        wait_for(0, 1, 1, 20, e);
        wait_for(0, 3, 1, 40, e);
        check_eq("s3_rehold_long", 32'(e), 32'(A_LP - 1));
        btn_a[1] = 1'b0;
        repeat (10) step();

        // simultaneous press on both channels
        btn_a = 2'b11;
        wait_for(0, 1, 0, 20, e);
        check_eq("s4_press_both", 32'(prs_a), 32'd3);

        // reset while held: silent drop, then full re-debounce
        rst = 1'b1;
        step();
        check_eq("s5_rst_level", 32'(lvl_a), 32'd0);
        check_eq("s5_rst_release", 32'(rel_a), 32'd0);
        rst = 1'b0;
        wait_for(0, 1, 0, 20, e);
        check_eq("s5_repress_edge", 32'(e), 32'd5);
        check_eq("s5_repress_both", 32'(prs_a), 32'd3);

        // divided sampling with fast release
        m = nb;
        btn_b[0] = 1'b1;
        wait_for(1, 1, 0, 60, e);
        check_eq("s6_press_edge", 32'(e), 32'(tick_edge(m, B_ST)));
        m = nb;
        btn_b[0] = 1'b0;
        wait_for(1, 5, 0, 20, e);
        check_eq("s6_fast_release", 32'(e), 32'(tick_edge(m, 1)));
        btn_a = '0;
        repeat (10) step();

        // random holds of all lengths, occasional reset
        for (int i = 0; i < A_CH; i++) ha[i] = 0;
        for (int i = 0; i < B_CH; i++) hb[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < A_CH; i++) begin
                if (ha[i] == 0) begin
                    btn_a[i] = 1'($urandom_range(0, 1));
                    ha[i] = $urandom_range(1, 45);
                end else ha[i]--;
            end
            for (int i = 0; i < B_CH; i++) begin
                if (hb[i] == 0) begin
                    btn_b[i] = 1'($urandom_range(0, 1));
                    hb[i] = $urandom_range(1, 120);
                end else hb[i]--;
            end
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
